// File: rtl/rx_word_packer.sv
// Packs four consecutive UART bytes (little-endian) into a 32-bit word and queues words in a FWFT FIFO.
// Optional inter-byte timeout that discards a stale partial word: define RX_WORD_TIMEOUT_EN.
module rx_word_packer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              rx_done_tick,
    output logic [31:0]       word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [1:0]        byte_idx,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              clear_ovf,
    output logic              timeout_err
);

    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [1:0]        state;
    logic [23:0]       pack;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    logic push_req;
    logic pop;
    logic push;
    logic drop;
    logic full;
    logic timeout_fire;

    assign full     = (count == FULL_COUNT);
    assign push_req = rx_done_tick && (state == B3);
    assign pop      = (count != '0) && word_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign byte_idx   = state;
    assign fifo_count = count;
    assign word_valid = (count != '0);
    assign word_out   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= B0;
            pack  <= '0;
        end else if (rx_done_tick) begin
            case (state)
                B0: begin pack[7:0]   <= din; state <= B1; end
                B1: begin pack[15:8]  <= din; state <= B2; end
                B2: begin pack[23:16] <= din; state <= B3; end
                default: begin pack <= '0; state <= B0; end
            endcase
        end else if (timeout_fire) begin
            state <= B0;
            pack  <= '0;
        end
    end

    // NOTE: storage array has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {din, pack};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef RX_WORD_TIMEOUT_EN
    localparam int            TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // An arriving byte always beats the timeout in the same cycle.
    assign timeout_fire = (state != B0) && !rx_done_tick && (to_cnt == TO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_fire;
            if (rx_done_tick || (state == B0) || timeout_fire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    logic timeout_cfg_unused;

    // Timeout length is meaningless without the counter; keep it referenced for lint.
    assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_fire       = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed self-checking bench for rx_word_packer (FIFO_DEPTH=4, TIMEOUT_CYCLES=20).
// Stimulus changes on the falling edge; outputs are checked on the falling edge.
module tb_rx_word_packer;

    logic        clock;
    logic        reset;
    logic [7:0]  din;
    logic        rx_done_tick;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [1:0]  byte_idx;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clear_ovf;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    rx_word_packer #(
        .FIFO_DEPTH     (4),
        .ADDR_W         (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .rx_done_tick (rx_done_tick),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .byte_idx     (byte_idx),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Entry and exit at a falling edge; successive calls give ticks on consecutive cycles.
    task automatic send_byte(input logic [7:0] b);
        din          = b;
        rx_done_tick = 1'b1;
        @(negedge clock);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic drain_expect(input string name, input logic [31:0] exp_w);
        n_cmp++;
        if (word_valid !== 1'b1 || word_out !== exp_w) begin
            n_err++;
            $display("FAIL %s: valid=%b word_out=%h, required valid=1 word_out=%h",
                     name, word_valid, word_out, exp_w);
        end
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        din          = 8'h00;
        rx_done_tick = 1'b0;
        word_ready   = 1'b0;
        clear_ovf    = 1'b0;
        idle(2);
        n_cmp++;
        if (byte_idx !== 2'd0 || word_valid !== 1'b0 || fifo_count !== 3'd0 ||
            overflow !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: idx=%0d valid=%b cnt=%0d ovf=%b to=%b, required all 0",
                     byte_idx, word_valid, fifo_count, overflow, timeout_err);
        end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_pack;
        send_byte(8'h78);
        send_byte(8'h56);
        n_cmp++;
        if (byte_idx !== 2'd2) begin
            n_err++;
            $display("FAIL basic_idx2: byte_idx=%0d, required 2", byte_idx);
        end
        send_byte(8'h34);
        n_cmp++;
        if (word_valid !== 1'b0 || byte_idx !== 2'd3) begin
            n_err++;
            $display("FAIL basic_3bytes: valid=%b idx=%0d, required valid=0 idx=3", word_valid, byte_idx);
        end
        send_byte(8'h12);
        n_cmp++;
        if (word_valid !== 1'b1 || word_out !== 32'h12345678 || fifo_count !== 3'd1 || byte_idx !== 2'd0) begin
            n_err++;
            $display("FAIL basic_word: valid=%b word=%h cnt=%0d idx=%0d, required 1 12345678 1 0",
                     word_valid, word_out, fifo_count, byte_idx);
        end
    endtask

    task automatic test_pop;
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
        n_cmp++;
        if (word_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL pop: valid=%b cnt=%0d, required valid=0 cnt=0", word_valid, fifo_count);
        end
        // Pop request on an empty FIFO must not underflow the count.
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 3'd0 || word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pop_empty: cnt=%0d valid=%b, required 0 0", fifo_count, word_valid);
        end
    endtask

    task automatic test_hold;
        send_byte(8'hA1);
        idle(5);
        n_cmp++;
        if (byte_idx !== 2'd1 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL hold_idle: idx=%0d to=%b, required idx=1 to=0", byte_idx, timeout_err);
        end
        send_byte(8'hB2);
        send_byte(8'hC3);
        idle(3);
        send_byte(8'hD4);
        drain_expect("hold_word", 32'hD4C3B2A1);
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fill: cnt=%0d ovf=%b, required cnt=4 ovf=0", fifo_count, overflow);
        end
        send_byte(8'hDD);
        send_byte(8'hCC);
        send_byte(8'hBB);
        clear_ovf = 1'b1;
        send_byte(8'hAA);
        clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4 || byte_idx !== 2'd0) begin
            n_err++;
            $display("FAIL overflow_set: ovf=%b cnt=%0d idx=%0d, required ovf=1 cnt=4 idx=0",
                     overflow, fifo_count, byte_idx);
        end
        drain_expect("drain_1", 32'h00000001);
        drain_expect("drain_2", 32'h00000002);
        drain_expect("drain_3", 32'h00000003);
        drain_expect("drain_4", 32'h00000004);
        n_cmp++;
        if (word_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty: valid=%b cnt=%0d ovf=%b, required 0 0 1",
                     word_valid, fifo_count, overflow);
        end
        clear_ovf = 1'b1;
        @(negedge clock);
        clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ovf: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        send_byte(8'h88);
        send_byte(8'h77);
        send_byte(8'h66);
        word_ready = 1'b1;
        send_byte(8'h55);
        word_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b, required cnt=4 ovf=0", fifo_count, overflow);
        end
        drain_expect("fpp_1", 32'h22222222);
        drain_expect("fpp_2", 32'h33333333);
        drain_expect("fpp_3", 32'h44444444);
        drain_expect("fpp_4", 32'h55667788);
        n_cmp++;
        if (word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fpp_empty: valid=%b, required 0", word_valid);
        end
    endtask

    task automatic test_async_reset;
        send_word(32'hCAFEF00D);
        send_byte(8'hEE);
        send_byte(8'hFF);
        n_cmp++;
        if (byte_idx !== 2'd2 || fifo_count !== 3'd1) begin
            n_err++;
            $display("FAIL pre_reset: idx=%0d cnt=%0d, required idx=2 cnt=1", byte_idx, fifo_count);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (byte_idx !== 2'd0 || fifo_count !== 3'd0 || word_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: idx=%0d cnt=%0d valid=%b, required 0 0 0",
                     byte_idx, fifo_count, word_valid);
        end
        #1 reset = 1'b1;
        @(negedge clock);
        send_word(32'h04030201);
        n_cmp++;
        if (word_out !== 32'h04030201 || fifo_count !== 3'd1) begin
            n_err++;
            $display("FAIL post_reset_word: word=%h cnt=%0d, required 04030201 1", word_out, fifo_count);
        end
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int pulses;
`ifdef RX_WORD_TIMEOUT_EN
        send_byte(8'h5A);
        pulses = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            if (timeout_err === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || byte_idx !== 2'd1) begin
            n_err++;
            $display("FAIL timeout_early: pulses=%0d idx=%0d, required 0 1", pulses, byte_idx);
        end
        @(negedge clock);
        n_cmp++;
        if (timeout_err !== 1'b1 || byte_idx !== 2'd0 || fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL timeout_fire: to=%b idx=%0d cnt=%0d, required 1 0 0",
                     timeout_err, byte_idx, fifo_count);
        end
        @(negedge clock);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse_width: to=%b, required 0", timeout_err);
        end
        send_byte(8'h11);
        pulses = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            if (timeout_err === 1'b1) pulses++;
        end
        send_byte(8'h22);
        if (timeout_err === 1'b1) pulses++;
        n_cmp++;
        if (pulses !== 0 || byte_idx !== 2'd2) begin
            n_err++;
            $display("FAIL timeout_tick_wins: pulses=%0d idx=%0d, required 0 2", pulses, byte_idx);
        end
`else
        send_byte(8'h5A);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (timeout_err === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || byte_idx !== 2'd1) begin
            n_err++;
            $display("FAIL no_timeout_hold: pulses=%0d idx=%0d, required 0 1", pulses, byte_idx);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_pop();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
